// File: rtl/fetch_unit.sv
// rv32i fetch stage: owns the PC and addresses an async-read ROM; the word lands in one registered slot for decode.
// Redirects flush the slot; a misaligned redirect or an out-of-range PC parks the stage in a sticky fault until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic {RUN, FAULT} state_e;

  // 33 bits so that ROM_WORDS*4 == 2^32 still compares correctly
  localparam logic [32:0] ROM_LIMIT = 33'(ROM_WORDS) * 33'd4;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] fpc_q, fpc_d;
  logic        slot_free;
  logic        pc_out_of_range;

  assign slot_free       = !valid_q || instr_ready;
  assign pc_out_of_range = {1'b0, pc_q} >= ROM_LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      fpc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fpc_q   <= fpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fpc_d   = fpc_q;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          // Any redirect flushes; a slot handshaken this same edge was still taken by decode
          valid_d = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            state_d = FAULT;
            fpc_d   = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (slot_free) begin
          if (pc_out_of_range) begin
            state_d = FAULT;
            fpc_d   = pc_q;
            valid_d = 1'b0;
          end else begin
            instr_d = rom_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end
      end
      FAULT: begin
        valid_d = 1'b0;
      end
    endcase
  end

  assign rom_addr    = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign fault       = (state_q == FAULT);
  assign fault_pc    = fpc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a ROM model feeds the DUT; expected {pc, word} pairs are queued as fetches
// are provoked and popped whenever decode accepts a slot.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] rom [0:31];
  logic [63:0] sb [$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb rom_data = (rom_addr < 32'd128) ? rom[rom_addr[6:2]] : 32'hBAD0_0BAD;

  fetch_unit #(.RESET_PC(32'h0), .ROM_WORDS(32)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fault(fault), .fault_pc(fault_pc)
  );

  function automatic void push_exp(input logic [31:0] pc);
    sb.push_back({pc, rom[pc[6:2]]});
  endfunction

  // Holds reset for two edges, then drops it on a falling edge; the next rising edge fetches RESET_PC
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h want=0", instr); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc got=%h want=0", instr_pc); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b want=0", fault); end
    checks++; if (fault_pc !== 32'h0) begin failures++; $display("FAIL reset_fault_pc got=%h want=0", fault_pc); end
    checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL reset_rom_addr got=%h want=0", rom_addr); end
  endtask

  task automatic test_free_run();
    logic [63:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL free_run_valid cyc=%0d got=%b want=1", cyc, instr_valid); end
      if (instr_valid && instr_ready) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL free_run_extra got pc=%h want none", instr_pc); end
        else begin
          exp = sb.pop_front();
          if ({instr_pc, instr} !== exp) begin failures++; $display("FAIL free_run_slot got=%h/%h want=%h/%h", instr_pc, instr, exp[63:32], exp[31:0]); end
        end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL free_run_left got=%0d want=0", sb.size()); end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      instr_ready = !(cyc >= 1 && cyc <= 3);
      if (cyc >= 1 && cyc <= 4) begin
        checks++;
        if (!(instr_valid === 1'b1 && instr_pc === 32'h4 && instr === rom[1] && rom_addr === 32'h8)) begin
          failures++;
          $display("FAIL bp_frozen cyc=%0d got v=%b pc=%h instr=%h addr=%h want v=1 pc=4 instr=%h addr=8",
                   cyc, instr_valid, instr_pc, instr, rom_addr, rom[1]);
        end
      end
      if (instr_valid && instr_ready) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL bp_extra got pc=%h want none", instr_pc); end
        else begin
          exp = sb.pop_front();
          if ({instr_pc, instr} !== exp) begin failures++; $display("FAIL bp_slot got=%h/%h want=%h/%h", instr_pc, instr, exp[63:32], exp[31:0]); end
        end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_left got=%0d want=0", sb.size()); end
  endtask

  task automatic test_redirect();
    logic [63:0] exp;
    do_reset();
    for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      redirect_valid = (cyc == 5);
      redirect_pc    = 32'h20;
      if (cyc == 5) begin
        checks++; if (instr_pc !== 32'h14) begin failures++; $display("FAIL redir_pre got=%h want=14", instr_pc); end
        push_exp(32'h20); push_exp(32'h24);
      end
      if (cyc == 6) begin
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble got=%b want=0", instr_valid); end
      end
      if (cyc == 7) begin
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL redir_target_valid got=%b want=1", instr_valid); end
      end
      if (instr_valid && instr_ready) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL redir_extra got pc=%h want none", instr_pc); end
        else begin
          exp = sb.pop_front();
          if ({instr_pc, instr} !== exp) begin failures++; $display("FAIL redir_slot got=%h/%h want=%h/%h", instr_pc, instr, exp[63:32], exp[31:0]); end
        end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL redir_left got=%0d want=0", sb.size()); end
  endtask

  task automatic test_misaligned();
    logic [63:0] exp;
    do_reset();
    push_exp(32'h0);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    if (instr_valid && instr_ready) begin
      checks++;
      exp = sb.pop_front();
      if ({instr_pc, instr} !== exp) begin failures++; $display("FAIL mis_slot got=%h/%h want=%h/%h", instr_pc, instr, exp[63:32], exp[31:0]); end
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h10;
      checks++;
      if (!(fault === 1'b1 && fault_pc === 32'h22 && instr_valid === 1'b0 && rom_addr === 32'h4)) begin
        failures++;
        $display("FAIL mis_fault cyc=%0d got f=%b fpc=%h v=%b addr=%h want f=1 fpc=22 v=0 addr=4",
                 cyc, fault, fault_pc, instr_valid, rom_addr);
      end
    end
    @(negedge clk);
    redirect_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!(fault === 1'b0 && fault_pc === 32'h0 && instr_valid === 1'b0 && rom_addr === 32'h0)) begin
      failures++;
      $display("FAIL mis_reset got f=%b fpc=%h v=%b addr=%h want f=0 fpc=0 v=0 addr=0", fault, fault_pc, instr_valid, rom_addr);
    end
    rst = 1'b0;
    sb.delete();
    push_exp(32'h0);
    @(negedge clk);
    checks++;
    if (!(instr_valid === 1'b1 && sb.size() == 1)) begin
      failures++; $display("FAIL mis_restart_valid got=%b want=1", instr_valid);
    end else begin
      exp = sb.pop_front();
      checks++;
      if ({instr_pc, instr} !== exp) begin failures++; $display("FAIL mis_restart got=%h/%h want=%h/%h", instr_pc, instr, exp[63:32], exp[31:0]); end
    end
  endtask

  task automatic test_range_fault();
    logic [63:0] exp;
    logic [31:0] last_pc;
    bit          seen;
    do_reset();
    for (int i = 0; i < 32; i++) push_exp(32'(i * 4));
    last_pc = 32'hFFFF_FFFF;
    seen    = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (fault) begin
        seen = 1'b1;
        checks++;
        if (!(fault_pc === 32'h80 && instr_valid === 1'b0 && cyc == 32 && last_pc === 32'h7C)) begin
          failures++;
          $display("FAIL range_fault got fpc=%h v=%b cyc=%0d last=%h want fpc=80 v=0 cyc=32 last=7c",
                   fault_pc, instr_valid, cyc, last_pc);
        end
        break;
      end
      if (instr_valid && instr_ready) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL range_extra got pc=%h want none", instr_pc); end
        else begin
          exp = sb.pop_front();
          last_pc = instr_pc;
          if ({instr_pc, instr} !== exp) begin failures++; $display("FAIL range_slot got=%h/%h want=%h/%h", instr_pc, instr, exp[63:32], exp[31:0]); end
        end
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL range_timeout got fault=0 want fault=1 within 40 cycles"); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL range_left got=%0d want=0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    do_reset();
    push_exp(32'h0);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      redirect_valid = (cyc == 0);
      redirect_pc    = 32'h8;
      if (cyc == 0) begin
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL b2b_pre_valid got=%b want=1", instr_valid); end
        push_exp(32'h8); push_exp(32'hC);
      end
      if (cyc == 1) begin
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b want=0", instr_valid); end
      end
      if (instr_valid && instr_ready) begin
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL b2b_extra got pc=%h want none", instr_pc); end
        else begin
          exp = sb.pop_front();
          if ({instr_pc, instr} !== exp) begin failures++; $display("FAIL b2b_slot got=%h/%h want=%h/%h", instr_pc, instr, exp[63:32], exp[31:0]); end
        end
      end
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_left got=%0d want=0", sb.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h02A0_0093;
    rom[2] = 32'h02A0_8093;
    rom[3] = 32'h0010_2023;
    for (int i = 4; i < 32; i++) rom[i] = 32'h1300_0000 | 32'(i * 32'h0001_0101);
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_range_fault();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
